// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller.
// FSM state encoding and forwarding-select encoding used by hazard_ctrl and fwd_sel.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_W   = 2'd1,
    FWD_M   = 2'd2
  } fwd_sel_t;

  localparam int LU_CNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select: purely combinational, zero latency, no backpressure.
// Memory-stage result wins over writeback; x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic                      reg_write_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_t                  sel_o
);

  logic m_hit;
  logic w_hit;

  assign m_hit = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i);
  assign w_hit = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i);

  always_comb begin
    sel_o = FWD_REG;
    if (m_hit) begin
      sel_o = FWD_M;
    end else if (w_hit) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV32 hazard controller: forwarding selects, stalls, flushes, dmem wait watchdog.
// Forwarding is 0-cycle; stalls/flushes are combinational from registered FSM state.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LU_STALLS      = 1,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic                      mem_read_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  input  logic                      pc_src_e,
  input  logic                      mem_access_m,
  input  logic                      dmem_busy,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      stall_m,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  hz_state_t             state_q, state_d, eff_state;
  logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  fwd_sel_t fwd_a, fwd_b;
  logic     mem_wait, lu_hazard, wd_hit;
  logic     st_f, st_d, st_e, st_m, fl_d, fl_e;

  fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i(rs1_e), .rd_m_i(rd_m), .reg_write_m_i(reg_write_m),
    .rd_w_i(rd_w), .reg_write_w_i(reg_write_w), .sel_o(fwd_a)
  );

  fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i(rs2_e), .rd_m_i(rd_m), .reg_write_m_i(reg_write_m),
    .rd_w_i(rd_w), .reg_write_w_i(reg_write_w), .sel_o(fwd_b)
  );

  assign mem_wait  = mem_access_m && dmem_busy;
  assign lu_hazard = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign wd_hit    = mem_wait && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d       = state_q;
    eff_state     = state_q;
    lu_cnt_d      = lu_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
    fl_d = 1'b0; fl_e = 1'b0;

    if (mem_wait) begin
      st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1;
      state_d = MEM_WAIT;
      if (wait_cnt_q != WAIT_LAST) wait_cnt_d = wait_cnt_q + 1'b1;
      if (wd_hit) mem_timeout_d = 1'b1;
    end else begin
      wait_cnt_d = '0;
      // Leaving MEM_WAIT resumes whatever load-use bubble count was pending.
      if (state_q == MEM_WAIT) eff_state = (lu_cnt_q != '0) ? LU_STALL : RUN;
      state_d = eff_state;
      if (pc_src_e) begin
        fl_d = 1'b1; fl_e = 1'b1;
        state_d  = RUN;
        lu_cnt_d = '0;
      end else if (eff_state == LU_STALL) begin
        st_f = 1'b1; st_d = 1'b1; fl_e = 1'b1;
        lu_cnt_d = lu_cnt_q - 1'b1;
        if (lu_cnt_q == LU_CNT_W'(1)) state_d = RUN;
      end else if (lu_hazard) begin
        st_f = 1'b1; st_d = 1'b1; fl_e = 1'b1;
        if (LU_STALLS > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_CNT_W'(LU_STALLS - 1);
        end
      end
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (st_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (fl_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      lu_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held, without waiting for a clock.
  assign forward_a_e = rst ? fwd_a : FWD_REG;
  assign forward_b_e = rst ? fwd_b : FWD_REG;
  assign stall_f     = rst & st_f;
  assign stall_d     = rst & st_d;
  assign stall_e     = rst & st_e;
  assign stall_m     = rst & st_m;
  assign flush_d     = rst & fl_d;
  assign flush_e     = rst & fl_e;
  assign mem_timeout = rst & (mem_timeout_q | wd_hit);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LU_STALLS=2, MEM_TIMEOUT=4, CNT_WIDTH=4.
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          mem_read_e, reg_write_m, reg_write_w, pc_src_e, mem_access_m, dmem_busy;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total  = 0;
  int passed = 0;

  hazard_ctrl #(.REG_ADDR_WIDTH(RW), .LU_STALLS(2), .MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .mem_access_m(mem_access_m), .dmem_busy(dmem_busy),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
  logic [5:0] ctl;
  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    mem_read_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    pc_src_e = 1'b0; mem_access_m = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5; rs2_e = 5'd5;
    mem_access_m = 1'b1; dmem_busy = 1'b1; pc_src_e = 1'b1;
    #12;
    total++;
    if ({forward_a_e, forward_b_e, ctl, mem_timeout, stall_cnt, flush_cnt} !== '0)
      $display("FAIL reset_outputs: got fa=%b fb=%b ctl=%b to=%b sc=%0d fc=%0d required all zero",
               forward_a_e, forward_b_e, ctl, mem_timeout, stall_cnt, flush_cnt);
    else passed++;
    @(negedge clk);
    idle();
    rst = 1'b1;
  endtask

  task automatic test_forwarding();
    logic [RW-1:0] v_rdm [7] = '{5, 0, 0, 5, 4, 9, 3};
    logic          v_wm  [7] = '{1, 1, 0, 0, 1, 1, 1};
    logic [RW-1:0] v_rdw [7] = '{5, 5, 5, 5, 3, 0, 3};
    logic          v_ww  [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [RW-1:0] v_rs1 [7] = '{5, 5, 6, 5, 3, 0, 3};
    logic [RW-1:0] v_rs2 [7] = '{1, 0, 5, 6, 4, 0, 3};
    logic [1:0]    e_a   [7] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic [1:0]    e_b   [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle();
      rd_m = v_rdm[i]; reg_write_m = v_wm[i]; rd_w = v_rdw[i]; reg_write_w = v_ww[i];
      rs1_e = v_rs1[i]; rs2_e = v_rs2[i];
      #1;
      total++;
      if ({forward_a_e, forward_b_e} !== {e_a[i], e_b[i]})
        $display("FAIL fwd_vec%0d: got a=%b b=%b required a=%b b=%b",
                 i, forward_a_e, forward_b_e, e_a[i], e_b[i]);
      else passed++;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_load_use();
    apply_reset();
    mem_read_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    #1;
    total++;
    if (ctl !== 6'b110001) $display("FAIL lu_cycle1: got ctl=%b required 110001", ctl);
    else passed++;
    @(negedge clk);
    idle();
    #1;
    total++;
    if (ctl !== 6'b110001) $display("FAIL lu_cycle2: got ctl=%b required 110001", ctl);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if ({ctl, stall_cnt, flush_cnt} !== {6'b000000, 4'd2, 4'd0})
      $display("FAIL lu_release: got ctl=%b sc=%0d fc=%0d required ctl=000000 sc=2 fc=0",
               ctl, stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_branch_vs_load_use();
    apply_reset();
    mem_read_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; pc_src_e = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b000011) $display("FAIL branch_beats_lu: got ctl=%b required 000011", ctl);
    else passed++;
    @(negedge clk);
    idle();
    #1;
    total++;
    if ({ctl, stall_cnt, flush_cnt} !== {6'b000000, 4'd0, 4'd1})
      $display("FAIL branch_after: got ctl=%b sc=%0d fc=%0d required ctl=000000 sc=0 fc=1",
               ctl, stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_mem_wait();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      mem_access_m = 1'b1; dmem_busy = 1'b1; pc_src_e = 1'b1;
      #1;
      total++;
      if ({ctl, mem_timeout} !== 7'b1111000)
        $display("FAIL mem_wait_c%0d: got ctl=%b to=%b required ctl=111100 to=0", c, ctl, mem_timeout);
      else passed++;
      @(negedge clk);
    end
    dmem_busy = 1'b0;
    #1;
    total++;
    if (ctl !== 6'b000011) $display("FAIL mem_wait_exit: got ctl=%b required 000011", ctl);
    else passed++;
    @(negedge clk);
    idle();
    #1;
    total++;
    if ({ctl, stall_cnt, flush_cnt, mem_timeout} !== {6'b000000, 4'd3, 4'd1, 1'b0})
      $display("FAIL mem_wait_after: got ctl=%b sc=%0d fc=%0d to=%b required 000000 sc=3 fc=1 to=0",
               ctl, stall_cnt, flush_cnt, mem_timeout);
    else passed++;
  endtask

  task automatic test_mem_wait_in_lu();
    apply_reset();
    mem_read_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9;
    @(negedge clk);
    idle();
    mem_access_m = 1'b1; dmem_busy = 1'b1;
    #1;
    total++;
    if (ctl !== 6'b111100) $display("FAIL lu_then_wait: got ctl=%b required 111100", ctl);
    else passed++;
    @(negedge clk);
    idle();
    #1;
    total++;
    if (ctl !== 6'b110001) $display("FAIL lu_resume: got ctl=%b required 110001", ctl);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if ({ctl, stall_cnt} !== {6'b000000, 4'd3})
      $display("FAIL lu_resume_done: got ctl=%b sc=%0d required ctl=000000 sc=3", ctl, stall_cnt);
    else passed++;
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      mem_access_m = 1'b1; dmem_busy = 1'b1;
      #1;
      total++;
      if (mem_timeout !== (c >= 3))
        $display("FAIL timeout_c%0d: got %b required %b", c, mem_timeout, (c >= 3));
      else passed++;
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_timeout, ctl} !== 7'b1000000)
      $display("FAIL timeout_sticky: got to=%b ctl=%b required to=1 ctl=000000", mem_timeout, ctl);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (mem_timeout !== 1'b0) $display("FAIL timeout_reset: got %b required 0", mem_timeout);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    apply_reset();
    mem_access_m = 1'b1; dmem_busy = 1'b1; pc_src_e = 1'b1;
    repeat (20) @(negedge clk);
    dmem_busy = 1'b0;
    repeat (18) @(negedge clk);
    idle();
    #1;
    total++;
    if ({stall_cnt, flush_cnt} !== {4'd15, 4'd15})
      $display("FAIL counter_saturate: got sc=%0d fc=%0d required sc=15 fc=15", stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    mem_read_e = 1'b1; rd_e = 5'd3; rs2_d = 5'd3;
    @(negedge clk);
    idle();
    #1;
    total++;
    if ({ctl, stall_cnt} !== {6'b110001, 4'd1})
      $display("FAIL arst_pre: got ctl=%b sc=%0d required ctl=110001 sc=1", ctl, stall_cnt);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({ctl, stall_cnt, flush_cnt} !== '0)
      $display("FAIL arst_immediate: got ctl=%b sc=%0d fc=%0d required all zero",
               ctl, stall_cnt, flush_cnt);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({ctl, stall_cnt} !== {6'b000000, 4'd0})
      $display("FAIL arst_run_after: got ctl=%b sc=%0d required ctl=000000 sc=0", ctl, stall_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_mem_wait_in_lu();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
